// File: rtl/fetch_pkg.sv
// Shared widths, FSM encoding and default halt word for the fetch unit.
package fetch_pkg;

  localparam int ADDR_W = 8;
  localparam int INST_W = 32;

  localparam logic [INST_W-1:0] HALT_WORD_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2
  } state_t;

endpackage

// File: rtl/fetch_fifo.sv
// Two-entry {pc, inst} buffer. The head entry lives in its own registers so
// the consumer sees registered outputs; the second entry waits in a tail slot.
module fetch_fifo
  import fetch_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic              flush,
  input  logic [ADDR_W-1:0] push_pc,
  input  logic [INST_W-1:0] push_inst,
  output logic [1:0]        count,
  output logic [ADDR_W-1:0] head_pc,
  output logic [INST_W-1:0] head_inst
);

  logic [ADDR_W-1:0] tail_pc;
  logic [INST_W-1:0] tail_inst;
  logic              do_pop;
  logic              do_push;

  // Qualify requests against occupancy; a full buffer takes a push only alongside a pop.
  always_comb begin
    do_pop  = pop && (count != 2'd0);
    do_push = push && ((count != 2'd2) || do_pop);
  end

  // Storage and occupancy update; flush empties the buffer without touching data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count     <= 2'd0;
      head_pc   <= '0;
      head_inst <= '0;
      tail_pc   <= '0;
      tail_inst <= '0;
    end else if (flush) begin
      count <= 2'd0;
    end else if (do_pop && do_push) begin
      if (count == 2'd1) begin
        head_pc   <= push_pc;
        head_inst <= push_inst;
      end else begin
        head_pc   <= tail_pc;
        head_inst <= tail_inst;
        tail_pc   <= push_pc;
        tail_inst <= push_inst;
      end
    end else if (do_pop) begin
      head_pc   <= tail_pc;
      head_inst <= tail_inst;
      count     <= count - 2'd1;
    end else if (do_push) begin
      if (count == 2'd0) begin
        head_pc   <= push_pc;
        head_inst <= push_inst;
      end else begin
        tail_pc   <= push_pc;
        tail_inst <= push_inst;
      end
      count <= count + 2'd1;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch front end: walks the ROM from RESET_PC, buffers up to two
// words for the consumer, stops on HALT_WORD and restarts on a redirect.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC  = 8'h04,
  parameter logic [INST_W-1:0] HALT_WORD = HALT_WORD_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [INST_W-1:0] rom_data,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [INST_W-1:0] inst,
  output logic [ADDR_W-1:0] inst_pc,
  output logic              halted
);

  state_t            state;
  logic [ADDR_W-1:0] pc;
  logic [1:0]        count;
  logic              fetch_en;
  logic              hit_halt;
  logic              push;
  logic              pop;
  logic [ADDR_W-1:0] target;

  // Fetch uses the occupancy at cycle start; redirect overrides fetch and pop.
  always_comb begin
    rom_addr   = pc;
    inst_valid = (count != 2'd0);
    target     = redirect_pc & 8'hFC;
    fetch_en   = (state == S_RUN) && !redirect_valid && (count < 2'd2);
    hit_halt   = (rom_data == HALT_WORD);
    push       = fetch_en && !hit_halt;
    pop        = inst_valid && inst_ready && !redirect_valid;
  end

  // Sequencing FSM with the pc and the registered halted flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_IDLE;
      pc     <= RESET_PC;
      halted <= 1'b0;
    end else begin
      if (redirect_valid) begin
        pc <= target;
      end else if (push) begin
        pc <= pc + 8'd4;
      end
      case (state)
        S_IDLE: begin
          if (start) state <= S_RUN;
        end
        S_RUN: begin
          if (fetch_en && hit_halt) begin
            state  <= S_HALT;
            halted <= 1'b1;
          end
        end
        S_HALT: begin
          if (redirect_valid) begin
            state  <= S_RUN;
            halted <= 1'b0;
          end
        end
        default: begin
          state  <= S_IDLE;
          halted <= 1'b0;
        end
      endcase
    end
  end

  fetch_fifo u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .pop       (pop),
    .flush     (redirect_valid),
    .push_pc   (pc),
    .push_inst (rom_data),
    .count     (count),
    .head_pc   (inst_pc),
    .head_inst (inst)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a small ROM model and hand-computed expectations.
module tb_fetch_unit;

  logic        clk;
  logic        rst;
  logic        start;
  logic [7:0]  rom_addr;
  logic [31:0] rom_data;
  logic        redirect_valid;
  logic [7:0]  redirect_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [7:0]  inst_pc;
  logic        halted;

  int checks = 0;
  int failures = 0;

  fetch_unit dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .rom_addr       (rom_addr),
    .rom_data       (rom_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst           (inst),
    .inst_pc        (inst_pc),
    .halted         (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ROM: a few fixed words, halt words at 0x00 and 0x48, address-tagged filler elsewhere.
  function automatic logic [31:0] rom_word(input logic [7:0] a);
    case (a)
      8'h00:   rom_word = 32'h0000_0000;
      8'h04:   rom_word = 32'h0045_0693;
      8'h08:   rom_word = 32'h0010_0713;
      8'h0c:   rom_word = 32'h00b7_6463;
      8'h20:   rom_word = 32'hffc6_2883;
      8'h48:   rom_word = 32'h0000_0000;
      default: rom_word = 32'h0100_0000 | {24'h0, a};
    endcase
  endfunction

  always_comb rom_data = rom_word(rom_addr);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    start = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = 8'h00;
    #12;
    rst = 1'b0;
    step();
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic redirect(input logic [7:0] target);
    redirect_valid = 1'b1;
    redirect_pc = target;
    step();
    redirect_valid = 1'b0;
  endtask

  initial begin
    inst_ready = 1'b1;
    do_reset();
    check("rst_valid", {31'h0, inst_valid}, 32'h0);
    check("rst_inst", inst, 32'h0);
    check("rst_inst_pc", {24'h0, inst_pc}, 32'h0);
    check("rst_halted", {31'h0, halted}, 32'h0);
    check("rst_rom_addr", {24'h0, rom_addr}, 32'h04);
    step(); step();
    check("idle_no_fetch", {31'h0, inst_valid}, 32'h0);

    // Streaming with ready held high: one instruction per cycle.
    pulse_start();
    step();
    check("seq0_valid", {31'h0, inst_valid}, 32'h1);
    check("seq0_pc", {24'h0, inst_pc}, 32'h04);
    check("seq0_inst", inst, 32'h0045_0693);
    step();
    check("seq1_pc", {24'h0, inst_pc}, 32'h08);
    check("seq1_inst", inst, 32'h0010_0713);
    step();
    check("seq2_pc", {24'h0, inst_pc}, 32'h0c);
    check("seq2_inst", inst, 32'h00b7_6463);

    // Backpressure: buffer fills to two, pc parks at 0x0c.
    do_reset();
    inst_ready = 1'b0;
    pulse_start();
    step(); step(); step(); step();
    check("bp_rom_addr", {24'h0, rom_addr}, 32'h0c);
    check("bp_head_pc", {24'h0, inst_pc}, 32'h04);
    check("bp_head_inst", inst, 32'h0045_0693);
    inst_ready = 1'b1;
    step();
    check("bp_pop1_pc", {24'h0, inst_pc}, 32'h08);
    check("bp_pop1_addr", {24'h0, rom_addr}, 32'h0c);
    step();
    check("bp_pop2_pc", {24'h0, inst_pc}, 32'h0c);
    check("bp_pop2_inst", inst, 32'h00b7_6463);

    // Redirect with two entries buffered; low bits of the target dropped.
    inst_ready = 1'b0;
    step(); step(); step();
    redirect(8'h22);
    check("rd_flush_valid", {31'h0, inst_valid}, 32'h0);
    check("rd_rom_addr", {24'h0, rom_addr}, 32'h20);
    step();
    check("rd_valid", {31'h0, inst_valid}, 32'h1);
    check("rd_pc", {24'h0, inst_pc}, 32'h20);
    check("rd_inst", inst, 32'hffc6_2883);

    // Redirect onto a halt word.
    redirect(8'h00);
    check("h_not_yet", {31'h0, halted}, 32'h0);
    step();
    check("h_halted", {31'h0, halted}, 32'h1);
    check("h_no_push", {31'h0, inst_valid}, 32'h0);
    check("h_rom_addr", {24'h0, rom_addr}, 32'h00);
    step();
    check("h_hold_addr", {24'h0, rom_addr}, 32'h00);
    redirect(8'h04);
    check("h_resume", {31'h0, halted}, 32'h0);
    step();
    check("h_resume_pc", {24'h0, inst_pc}, 32'h04);
    check("h_resume_inst", inst, 32'h0045_0693);

    // Halt with an entry still buffered; it drains while halted.
    redirect(8'h44);
    step(); step();
    check("dr_halted", {31'h0, halted}, 32'h1);
    check("dr_valid", {31'h0, inst_valid}, 32'h1);
    check("dr_pc", {24'h0, inst_pc}, 32'h44);
    inst_ready = 1'b1;
    step();
    check("dr_empty", {31'h0, inst_valid}, 32'h0);
    check("dr_still_halted", {31'h0, halted}, 32'h1);

    // Redirect and pop together with one entry: pop ignored, target honoured.
    inst_ready = 1'b0;
    redirect(8'h04);
    step();
    check("rp_one_entry", {24'h0, inst_pc}, 32'h04);
    inst_ready = 1'b1;
    redirect(8'h21);
    check("rp_flushed", {31'h0, inst_valid}, 32'h0);
    check("rp_target", {24'h0, rom_addr}, 32'h20);
    inst_ready = 1'b0;
    step();
    check("rp_new_pc", {24'h0, inst_pc}, 32'h20);
    check("rp_new_inst", inst, 32'hffc6_2883);

    // pc wraps 0xfc -> 0x00 and then meets the halt word.
    inst_ready = 1'b1;
    redirect(8'hfc);
    step();
    check("wrap_pc", {24'h0, inst_pc}, 32'hfc);
    check("wrap_inst", inst, 32'h0100_00fc);
    check("wrap_addr", {24'h0, rom_addr}, 32'h00);
    step();
    check("wrap_halt", {31'h0, halted}, 32'h1);

    // Asynchronous reset mid-stream with two entries buffered.
    inst_ready = 1'b0;
    redirect(8'h04);
    step(); step();
    check("ar_pre_valid", {31'h0, inst_valid}, 32'h1);
    #2 rst = 1'b1;
    #1;
    check("ar_valid", {31'h0, inst_valid}, 32'h0);
    check("ar_rom_addr", {24'h0, rom_addr}, 32'h04);
    check("ar_inst_pc", {24'h0, inst_pc}, 32'h00);
    #10 rst = 1'b0;
    step(); step(); step();
    check("ar_idle", {31'h0, inst_valid}, 32'h0);
    check("ar_idle_addr", {24'h0, rom_addr}, 32'h04);
    pulse_start();
    step();
    check("ar_restart_pc", {24'h0, inst_pc}, 32'h04);
    check("ar_restart_inst", inst, 32'h0045_0693);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
